uart_loader: RTL



---
 rtl/uart_loader_pkg.sv | 34 +++
 rtl/uart_loader_timeout.sv | 27 ++
 rtl/uart_loader.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_loader_pkg.sv
// rtl/uart_loader_pkg.sv - shared constants, state encoding and helpers for the UART load-frame decoder
package uart_loader_pkg;

   localparam logic [23:0] TIMEOUT_DEFAULT = 24'd2160000;
   localparam logic [7:0]  SYNC_DEFAULT    = 8'h55;
   localparam logic [7:0]  ACK_DEFAULT     = 8'h06;
   localparam logic [7:0]  NAK_DEFAULT     = 8'h15;

   localparam logic [7:0]  CMD_WRITE = 8'h57;
   localparam logic [7:0]  CMD_PING  = 8'h50;

   localparam int ERR_CHK = 0;
   localparam int ERR_TMO = 1;
   localparam int ERR_OVR = 2;

   typedef enum logic [3:0] {
      S_IDLE,
      S_CMD,
      S_A2,
      S_A1,
      S_A0,
      S_LEN,
      S_DATA,
      S_CHK,
      S_RESP
   } state_t;

   // A frame is only acknowledged when no error flag is set and the command was recognised.
   function automatic logic [7:0] resp_byte(input logic [2:0] err, input logic bad_cmd,
                                            input logic [7:0] ack, input logic [7:0] nak);
      return ((err != 3'b000) || bad_cmd) ? nak : ack;
   endfunction

endpackage

// File: rtl/uart_loader_timeout.sv
// rtl/uart_loader_timeout.sv - loadable inter-byte down-counter, EXPIRE after P_LOAD idle cycles
module uart_loader_timeout #(
   parameter logic [23:0] P_LOAD = 24'd2160000
) (
   input  logic CLK,
   input  logic RESETB,
   input  logic RESTART,
   input  logic ENABLE,
   output logic EXPIRE
);

   logic [23:0] cnt;

   always_ff @(posedge CLK or negedge RESETB) begin
      if (!RESETB) begin
         cnt <= '0;
      end else if (RESTART || !ENABLE) begin
         cnt <= P_LOAD - 24'd1;
      end else if (cnt != 24'd0) begin
         cnt <= cnt - 24'd1;
      end
   end

   // A byte arriving in the expiry cycle wins over the timeout.
   assign EXPIRE = ENABLE && !RESTART && (cnt == 24'd0);

endmodule

// File: rtl/uart_loader.sv
// rtl/uart_loader.sv - host load-frame decoder writing payload to memory; UART_LOADER_CPU_HOLD_EN adds CPU_HOLD
module uart_loader
   import uart_loader_pkg::*;
#(
   parameter logic [23:0] P_TIMEOUT = TIMEOUT_DEFAULT,
   parameter logic [7:0]  P_SYNC    = SYNC_DEFAULT,
   parameter logic [7:0]  P_ACK     = ACK_DEFAULT,
   parameter logic [7:0]  P_NAK     = NAK_DEFAULT
) (
   input  logic        CLK,
   input  logic        RESETB,
   input  logic [7:0]  RX_DATA,
   input  logic        RX_DATA_EN,
   output logic [7:0]  TX_DATA,
   output logic        TX_DATA_EN,
   input  logic        TX_BUSY,
   output logic [23:0] MEM_ADDR,
   output logic [7:0]  MEM_WDATA,
   output logic        MEM_WE,
   input  logic        MEM_BUSY,
   output logic        LOAD_ACTIVE,
`ifdef UART_LOADER_CPU_HOLD_EN
   output logic        CPU_HOLD,
`endif
   output logic [2:0]  ERR_FLAGS
);

   state_t      state, state_nxt;
   logic [23:0] addr_nxt;
   logic [8:0]  cnt, cnt_nxt;
   logic [7:0]  sum, sum_nxt;
   logic [7:0]  wdata_nxt;
   logic        we_nxt;
   logic [2:0]  err_nxt;
   logic        bad_cmd, bad_cmd_nxt;
   logic        active_nxt;
   logic [7:0]  txd_nxt;
   logic        txen_nxt;
   logic        hold, hold_nxt;

   logic        wr_done;
   logic        wr_stall;
   logic        in_frame;
   logic        rx_in_frame;
   logic [7:0]  chk_sum;
   logic        tmo_expire;

   assign wr_done     = MEM_WE && !MEM_BUSY;
   assign wr_stall    = MEM_WE && MEM_BUSY;
   assign in_frame    = (state != S_IDLE) && (state != S_RESP);
   assign rx_in_frame = RX_DATA_EN && in_frame;
   assign chk_sum     = sum + RX_DATA;

   uart_loader_timeout #(
      .P_LOAD (P_TIMEOUT)
   ) u_timeout (
      .CLK     (CLK),
      .RESETB  (RESETB),
      .RESTART (RX_DATA_EN),
      .ENABLE  (in_frame),
      .EXPIRE  (tmo_expire)
   );

   always_ff @(posedge CLK or negedge RESETB) begin
      if (!RESETB) begin
         state       <= S_IDLE;
         MEM_ADDR    <= '0;
         cnt         <= '0;
         sum         <= '0;
         MEM_WDATA   <= '0;
         MEM_WE      <= 1'b0;
         ERR_FLAGS   <= '0;
         bad_cmd     <= 1'b0;
         LOAD_ACTIVE <= 1'b0;
         TX_DATA     <= '0;
         TX_DATA_EN  <= 1'b0;
         hold        <= 1'b0;
      end else begin
         state       <= state_nxt;
         MEM_ADDR    <= addr_nxt;
         cnt         <= cnt_nxt;
         sum         <= sum_nxt;
         MEM_WDATA   <= wdata_nxt;
         MEM_WE      <= we_nxt;
         ERR_FLAGS   <= err_nxt;
         bad_cmd     <= bad_cmd_nxt;
         LOAD_ACTIVE <= active_nxt;
         TX_DATA     <= txd_nxt;
         TX_DATA_EN  <= txen_nxt;
         hold        <= hold_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      addr_nxt    = MEM_ADDR;
      cnt_nxt     = cnt;
      sum_nxt     = sum;
      wdata_nxt   = MEM_WDATA;
      we_nxt      = MEM_WE;
      err_nxt     = ERR_FLAGS;
      bad_cmd_nxt = bad_cmd;
      active_nxt  = LOAD_ACTIVE;
      txd_nxt     = TX_DATA;
      txen_nxt    = 1'b0;
      hold_nxt    = hold;

      if (wr_done) begin
         we_nxt   = 1'b0;
         addr_nxt = MEM_ADDR + 24'd1;
      end

      // Every in-frame byte is summed, including an overrun byte, so the checksum still lines up.
      if (rx_in_frame) begin
         sum_nxt = chk_sum;
         if (wr_stall) begin
            err_nxt[ERR_OVR] = 1'b1;
         end
      end

      case (state)
         S_IDLE: begin
            if (RX_DATA_EN && (RX_DATA == P_SYNC)) begin
               state_nxt   = S_CMD;
               err_nxt     = '0;
               bad_cmd_nxt = 1'b0;
               active_nxt  = 1'b1;
               sum_nxt     = '0;
            end
         end
         S_CMD: begin
            if (RX_DATA_EN) begin
               if (RX_DATA == CMD_WRITE) begin
                  state_nxt = S_A2;
                  hold_nxt  = 1'b1;
               end else if (RX_DATA == CMD_PING) begin
                  state_nxt = S_CHK;
               end else begin
                  state_nxt   = S_RESP;
                  bad_cmd_nxt = 1'b1;
               end
            end
         end
         S_A2: begin
            if (RX_DATA_EN) begin
               addr_nxt  = {RX_DATA, MEM_ADDR[15:0]};
               state_nxt = S_A1;
            end
         end
         S_A1: begin
            if (RX_DATA_EN) begin
               addr_nxt  = {MEM_ADDR[23:16], RX_DATA, MEM_ADDR[7:0]};
               state_nxt = S_A0;
            end
         end
         S_A0: begin
            if (RX_DATA_EN) begin
               addr_nxt  = {MEM_ADDR[23:8], RX_DATA};
               state_nxt = S_LEN;
            end
         end
         S_LEN: begin
            if (RX_DATA_EN) begin
               cnt_nxt   = {1'b0, RX_DATA} + 9'd1;
               state_nxt = S_DATA;
            end
         end
         S_DATA: begin
            if (RX_DATA_EN) begin
               cnt_nxt = cnt - 9'd1;
               if (cnt == 9'd1) begin
                  state_nxt = S_CHK;
               end
               if (!wr_stall) begin
                  wdata_nxt = RX_DATA;
                  we_nxt    = 1'b1;
               end
            end
         end
         S_CHK: begin
            if (RX_DATA_EN) begin
               if (chk_sum != 8'h00) begin
                  err_nxt[ERR_CHK] = 1'b1;
               end
               state_nxt = S_RESP;
            end
         end
         S_RESP: begin
            if (TX_DATA_EN) begin
               state_nxt  = S_IDLE;
               active_nxt = 1'b0;
               hold_nxt   = 1'b0;
            end else if (!TX_BUSY && !MEM_WE) begin
               txen_nxt = 1'b1;
               txd_nxt  = resp_byte(ERR_FLAGS, bad_cmd, P_ACK, P_NAK);
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase

      if (tmo_expire) begin
         err_nxt[ERR_TMO] = 1'b1;
         we_nxt           = 1'b0;
         state_nxt        = S_RESP;
      end
   end

`ifdef UART_LOADER_CPU_HOLD_EN
   assign CPU_HOLD = hold;
`else
   logic unused_hold;
   assign unused_hold = hold;
`endif

endmodule
